// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-ported memory between the
// fetch (I) and memory (D) pipeline stages using req/done handshakes.
// Optional build macro ARB_RR_EN: ties alternate between the two sides
// instead of always favouring D.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q;
   logic               wr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               cancel_q, cancel_d;
   logic               i_elig, d_elig, d_wins_tie;
   logic               grant_i, grant_d, fin_i, fin_d;

   // A side is eligible only while requesting and not in its own done cycle
   assign i_elig = i_req & ~i_done & ~i_flush;
   assign d_elig = d_req & ~d_done;

`ifdef ARB_RR_EN
   logic last_grant_q;  // 0 = I granted last, 1 = D granted last

   // Remember the most recent winner so ties alternate
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          last_grant_q <= 1'b0;
      else if (grant_d) last_grant_q <= 1'b1;
      else if (grant_i) last_grant_q <= 1'b0;
   end

   assign d_wins_tie = ~last_grant_q;
`else
   assign d_wins_tie = 1'b1;
`endif

   // Next-state, grant and completion decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cancel_d = cancel_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      fin_i    = 1'b0;
      fin_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (d_elig && (!i_elig || d_wins_tie)) begin
               grant_d = 1'b1;
               state_d = BUSY_D;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end else if (i_elig) begin
               grant_i = 1'b1;
               state_d = BUSY_I;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end
         end
         BUSY_I: begin
            if (i_flush) cancel_d = 1'b1;
            if (cnt_q == '0) begin
               fin_i    = ~(cancel_q | i_flush);
               cancel_d = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BUSY_D: begin
            if (cnt_q == '0) begin
               fin_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and cancel flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
      end
   end

   // Latch the winner's request so the memory sees stable inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else if (grant_d) begin
         addr_q  <= d_addr;
         wr_q    <= d_wr;
         wdata_q <= d_wdata;
      end else if (grant_i) begin
         addr_q  <= i_addr;
         wr_q    <= 1'b0;
      end
   end

   // Completion pulses and read-data capture; stores leave d_rdata alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_done <= fin_i;
         d_done <= fin_d;
         if (fin_i)         i_rdata <= mem_rdata;
         if (fin_d && !wr_q) d_rdata <= mem_rdata;
      end
   end

   assign mem_en    = (state_q != IDLE);
   assign mem_wr    = (state_q == BUSY_D) & wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Stalls follow the live handshake; forced low while reset is held
   assign i_stall = ~rst & i_req & ~i_done & ~i_flush;
   assign d_stall = ~rst & d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=4.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_flush, i_done, i_stall;
   logic [15:0] i_addr, i_rdata;
   logic        d_req, d_wr, d_done, d_stall;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_req = 0; i_flush = 0; i_addr = '0;
      d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      tick(); tick();
      checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
      checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      checks++; if ({i_done, d_done, i_stall, d_stall, mem_wr} !== 5'b0)
         begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {i_done, d_done, i_stall, d_stall, mem_wr}); end
      checks++; if ({i_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      d_addr = 16'h0010; d_wr = 0; d_req = 1; mem_rdata = 16'hBEEF;
      #1;
      checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL load_stall_T got=%b exp=1", d_stall); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_wr, d_done, d_stall} !== 4'b1001 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL load_busy c%0d got en/wr/done/stall=%b addr=%h exp=1001 0010", k, {mem_en, mem_wr, d_done, d_stall}, mem_addr);
         end
      end
      tick();
      checks++; if ({d_done, d_stall, mem_en} !== 3'b100) begin errors++; $display("FAIL load_done got done/stall/en=%b exp=100", {d_done, d_stall, mem_en}); end
      checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=beef", d_rdata); end
      d_req = 0;
      tick();
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse got=%b exp=0", d_done); end
   endtask

   task automatic test_store();
      d_addr = 16'h0020; d_wr = 1; d_wdata = 16'h1234; d_req = 1; mem_rdata = 16'h7777;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store_busy c%0d got en/wr=%b addr=%h wdata=%h exp=11 0020 1234", k, {mem_en, mem_wr}, mem_addr, mem_wdata);
         end
      end
      tick();
      checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", d_done); end
      checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL store_rdata_kept got=%h exp=beef", d_rdata); end
      d_req = 0; d_wr = 0;
      tick();
   endtask

   task automatic test_priority();
      i_addr = 16'h0030; d_addr = 16'h0050; i_req = 1; d_req = 1; mem_rdata = 16'h2222;
      #1;
      checks++; if ({i_stall, d_stall} !== 2'b11) begin errors++; $display("FAIL prio_stall_T got=%b exp=11", {i_stall, d_stall}); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (mem_addr !== 16'h0050 || {mem_en, i_stall, i_done} !== 3'b110) begin
            errors++;
            $display("FAIL prio_d_busy c%0d got addr=%h en/istall/idone=%b exp=0050 110", k, mem_addr, {mem_en, i_stall, i_done});
         end
      end
      tick();
      checks++; if ({d_done, i_stall, mem_en} !== 3'b110 || d_rdata !== 16'h2222)
         begin errors++; $display("FAIL prio_d_done got done/istall/en=%b rdata=%h exp=110 2222", {d_done, i_stall, mem_en}, d_rdata); end
      d_req = 0; mem_rdata = 16'h1111;
      for (int k = 6; k <= 9; k++) begin
         tick();
         checks++;
         if (mem_addr !== 16'h0030 || {mem_en, mem_wr, i_stall, i_done} !== 4'b1010) begin
            errors++;
            $display("FAIL prio_i_busy c%0d got addr=%h en/wr/stall/done=%b exp=0030 1010", k, mem_addr, {mem_en, mem_wr, i_stall, i_done});
         end
      end
      tick();
      checks++; if ({i_done, i_stall} !== 2'b10 || i_rdata !== 16'h1111)
         begin errors++; $display("FAIL prio_i_done got done/stall=%b rdata=%h exp=10 1111", {i_done, i_stall}, i_rdata); end
      i_req = 0;
      tick();
   endtask

   task automatic test_flush();
      i_addr = 16'h0040; i_req = 1; mem_rdata = 16'hDEAD;
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL flush_c1 got en=%b addr=%h exp=1 0040", mem_en, mem_addr); end
      tick();
      i_flush = 1;
      #1;
      checks++; if ({mem_en, i_stall} !== 2'b10) begin errors++; $display("FAIL flush_c2 got en/stall=%b exp=10", {mem_en, i_stall}); end
      tick();
      i_flush = 0; i_req = 0;
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL flush_c3 got en=%b exp=1", mem_en); end
      tick();
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL flush_c4 got en=%b exp=1", mem_en); end
      tick();
      checks++; if ({mem_en, i_done} !== 2'b00 || i_rdata !== 16'h1111)
         begin errors++; $display("FAIL flush_suppress got en/done=%b rdata=%h exp=00 1111", {mem_en, i_done}, i_rdata); end
      tick();
      checks++; if (i_done !== 1'b0) begin errors++; $display("FAIL flush_no_late_done got=%b exp=0", i_done); end
      i_addr = 16'h0042; i_req = 1; mem_rdata = 16'h5A5A;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (mem_en !== 1'b1 || mem_addr !== 16'h0042) begin errors++; $display("FAIL refetch_busy c%0d got en=%b addr=%h exp=1 0042", k, mem_en, mem_addr); end
      end
      tick();
      checks++; if (i_done !== 1'b1 || i_rdata !== 16'h5A5A) begin errors++; $display("FAIL refetch_done got done=%b rdata=%h exp=1 5a5a", i_done, i_rdata); end
      i_req = 0;
      tick();
   endtask

   task automatic test_ties();
      logic exp_d;
      for (int r = 0; r < 3; r++) begin
`ifdef ARB_RR_EN
         exp_d = (r != 1);
`else
         exp_d = 1'b1;
`endif
         i_addr = 16'h0060; d_addr = 16'h0070; d_wr = 0; i_req = 1; d_req = 1;
         mem_rdata = 16'(r);
         tick();
         checks++;
         if (mem_addr !== (exp_d ? 16'h0070 : 16'h0060))
            begin errors++; $display("FAIL tie%0d_winner got addr=%h exp=%h", r, mem_addr, exp_d ? 16'h0070 : 16'h0060); end
         if (exp_d) i_req = 0; else d_req = 0;
         tick(); tick(); tick(); tick();
         checks++;
         if ({d_done, i_done} !== (exp_d ? 2'b10 : 2'b01))
            begin errors++; $display("FAIL tie%0d_done got d/i=%b exp=%b", r, {d_done, i_done}, exp_d ? 2'b10 : 2'b01); end
         i_req = 0; d_req = 0;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      d_addr = 16'h0080; d_wr = 0; d_req = 1; mem_rdata = 16'h3333;
      tick(); tick(); tick();
      rst = 1; d_req = 0;
      #1;
      checks++; if ({mem_en, mem_wr, d_done, d_stall, i_done} !== 5'b0 || mem_addr !== 16'h0)
         begin errors++; $display("FAIL rst_mid_ctrl got=%b addr=%h exp=00000 0000", {mem_en, mem_wr, d_done, d_stall, i_done}, mem_addr); end
      checks++; if ({d_rdata, i_rdata} !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=0", {d_rdata, i_rdata}); end
      tick(); tick();
      rst = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({mem_en, d_done} !== 2'b00) begin errors++; $display("FAIL rst_mid_quiet c%0d got en/done=%b exp=00", k, {mem_en, d_done}); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_priority();
      test_flush();
      test_ties();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
